// File: rtl/corebootstrap_spi_arb.sv
`default_nettype none
// corebootstrap_spi_arb: shares one SPI flash between the bootstrap copy engine (priority)
// and NUM_HOSTS round-robin host masters, with a guard gap (SS high) on every owner change.
module corebootstrap_spi_arb #(
   parameter int unsigned NUM_HOSTS    = 2,
   parameter int unsigned GUARD_CYCLES = 4,
   parameter logic        IDLE_SCK     = 1'b0
) (
   input  logic                 HCLK,
   input  logic                 HRESETN,
   input  logic                 PROC_SYS_RESETN,
   input  logic                 boot_active,
   input  logic                 boot_sck,
   input  logic                 boot_sdo,
   input  logic                 boot_ss,
   output logic                 boot_sdi,
   input  logic [NUM_HOSTS-1:0] HOST_REQ,
   output logic [NUM_HOSTS-1:0] HOST_GNT,
   input  logic [NUM_HOSTS-1:0] HOST_SCK,
   input  logic [NUM_HOSTS-1:0] HOST_SDO,
   input  logic [NUM_HOSTS-1:0] HOST_SS,
   output logic [NUM_HOSTS-1:0] HOST_SDI,
   output logic                 FLASH_SCK,
   output logic                 FLASH_SDO,
   output logic                 FLASH_SS,
   input  logic                 FLASH_SDI,
   output logic                 ss_violation
);

   localparam int unsigned IDX_W      = (NUM_HOSTS > 1) ? $clog2(NUM_HOSTS) : 1;
   localparam logic [7:0]  GUARD_LOAD = 8'(GUARD_CYCLES - 1);

   localparam logic [1:0] ST_BOOT  = 2'd0;
   localparam logic [1:0] ST_GUARD = 2'd1;
   localparam logic [1:0] ST_IDLE  = 2'd2;
   localparam logic [1:0] ST_HOST  = 2'd3;

   logic [1:0]           state_q, state_d;
   logic [IDX_W-1:0]     cur_q, cur_d;
   logic [IDX_W-1:0]     nxt_q, nxt_d;
   logic [7:0]           cnt_q, cnt_d;
   logic [NUM_HOSTS-1:0] gnt_q, gnt_d;
   logic                 viol_q, viol_d;

   logic                 req_found;
   logic [IDX_W-1:0]     req_pick;
   logic [IDX_W-1:0]     cur_inc;
   logic [31:0]          scan_idx;

   // Round-robin search: first requester at or after nxt, wrapping at NUM_HOSTS.
   always_comb begin
      req_found = 1'b0;
      req_pick  = nxt_q;
      scan_idx  = 32'd0;
      for (int unsigned i = 0; i < NUM_HOSTS; i++) begin
         scan_idx = 32'(nxt_q) + 32'(i);
         if (scan_idx >= 32'(NUM_HOSTS)) begin
            scan_idx = scan_idx - 32'(NUM_HOSTS);
         end
         if (!req_found && HOST_REQ[scan_idx[IDX_W-1:0]]) begin
            req_found = 1'b1;
            req_pick  = scan_idx[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      if (32'(cur_q) + 32'd1 >= 32'(NUM_HOSTS)) begin
         cur_inc = '0;
      end else begin
         cur_inc = cur_q + IDX_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      nxt_d   = nxt_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_BOOT: begin
            if (!boot_active && boot_ss) begin
               state_d = ST_GUARD;
               cnt_d   = GUARD_LOAD;
            end
         end
         ST_GUARD: begin
            if (cnt_q == 8'd0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_IDLE: begin
            if (boot_active) begin
               state_d = ST_BOOT;
            end else if (PROC_SYS_RESETN && req_found) begin
               state_d = ST_HOST;
               cur_d   = req_pick;
            end
         end
         ST_HOST: begin
            // A host CPU reset aborts the transfer without advancing fairness.
            if (!PROC_SYS_RESETN) begin
               state_d = ST_GUARD;
               cnt_d   = GUARD_LOAD;
            end else if (!HOST_REQ[cur_q] && HOST_SS[cur_q]) begin
               state_d = ST_GUARD;
               cnt_d   = GUARD_LOAD;
               nxt_d   = cur_inc;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase

      gnt_d = '0;
      if (state_d == ST_HOST) begin
         gnt_d[cur_d] = 1'b1;
      end

      viol_d = PROC_SYS_RESETN && (|(~HOST_SS & ~gnt_q));
   end

   always_ff @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN) begin
         state_q <= ST_BOOT;
         cur_q   <= '0;
         nxt_q   <= '0;
         cnt_q   <= 8'd0;
         gnt_q   <= '0;
         viol_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         nxt_q   <= nxt_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         viol_q  <= viol_d;
      end
   end

   always_comb begin
      FLASH_SS  = 1'b1;
      FLASH_SCK = IDLE_SCK;
      FLASH_SDO = 1'b0;
      if (state_q == ST_BOOT) begin
         FLASH_SS  = boot_ss;
         FLASH_SCK = boot_sck;
         FLASH_SDO = boot_sdo;
      end else if (state_q == ST_HOST) begin
         FLASH_SS  = HOST_SS[cur_q];
         FLASH_SCK = HOST_SCK[cur_q];
         FLASH_SDO = HOST_SDO[cur_q];
      end
   end

   assign boot_sdi     = FLASH_SDI;
   assign HOST_SDI     = {NUM_HOSTS{FLASH_SDI}};
   assign HOST_GNT     = gnt_q;
   assign ss_violation = viol_q;

endmodule
`default_nettype wire

// File: tb/tb_corebootstrap_spi_arb.sv
`default_nettype none
// Bench for corebootstrap_spi_arb: directed scenarios plus random traffic, all compared
// against a bus-ownership model (boot / none / host index, guard countdown, rr pointer).
module tb_corebootstrap_spi_arb;

   localparam int   NH       = 2;
   localparam int   G        = 4;
   localparam logic IDLE_SCK = 1'b0;
   localparam int   OWN_BOOT = -2;
   localparam int   OWN_NONE = -1;

   logic          HCLK = 1'b0;
   logic          HRESETN = 1'b1;
   logic          PROC_SYS_RESETN;
   logic          boot_active, boot_sck, boot_sdo, boot_ss, boot_sdi;
   logic [NH-1:0] HOST_REQ, HOST_GNT, HOST_SCK, HOST_SDO, HOST_SS, HOST_SDI;
   logic          FLASH_SCK, FLASH_SDO, FLASH_SS, FLASH_SDI, ss_violation;

   int   n_checks = 0;
   int   n_fail   = 0;

   int   m_own   = OWN_BOOT;
   int   m_guard = 0;
   int   m_rr    = 0;
   logic m_viol  = 1'b0;

   logic [15:0] act_bus;

   corebootstrap_spi_arb #(
      .NUM_HOSTS   (NH),
      .GUARD_CYCLES(G),
      .IDLE_SCK    (IDLE_SCK)
   ) dut (
      .HCLK           (HCLK),
      .HRESETN        (HRESETN),
      .PROC_SYS_RESETN(PROC_SYS_RESETN),
      .boot_active    (boot_active),
      .boot_sck       (boot_sck),
      .boot_sdo       (boot_sdo),
      .boot_ss        (boot_ss),
      .boot_sdi       (boot_sdi),
      .HOST_REQ       (HOST_REQ),
      .HOST_GNT       (HOST_GNT),
      .HOST_SCK       (HOST_SCK),
      .HOST_SDO       (HOST_SDO),
      .HOST_SS        (HOST_SS),
      .HOST_SDI       (HOST_SDI),
      .FLASH_SCK      (FLASH_SCK),
      .FLASH_SDO      (FLASH_SDO),
      .FLASH_SS       (FLASH_SS),
      .FLASH_SDI      (FLASH_SDI),
      .ss_violation   (ss_violation)
   );

   always #5 HCLK = ~HCLK;

   assign act_bus = {7'b0, HOST_GNT, FLASH_SS, FLASH_SCK, FLASH_SDO, ss_violation, boot_sdi, HOST_SDI};

   // Ownership model: who owns the flash, how many guard cycles remain, whose turn is next.
   always @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN) begin
         m_own   <= OWN_BOOT;
         m_guard <= 0;
         m_rr    <= 0;
         m_viol  <= 1'b0;
      end else begin : model_step
         automatic int   own_n   = m_own;
         automatic int   guard_n = m_guard;
         automatic int   rr_n    = m_rr;
         automatic logic v       = 1'b0;
         for (int h = 0; h < NH; h++) begin
            if (PROC_SYS_RESETN && h != m_own && !HOST_SS[h]) v = 1'b1;
         end
         if (m_guard > 0) begin
            guard_n = m_guard - 1;
         end else if (m_own == OWN_BOOT) begin
            if (!boot_active && boot_ss) begin
               own_n   = OWN_NONE;
               guard_n = G;
            end
         end else if (m_own == OWN_NONE) begin
            if (boot_active) begin
               own_n = OWN_BOOT;
            end else if (PROC_SYS_RESETN) begin
               for (int k = NH - 1; k >= 0; k--) begin
                  if (HOST_REQ[(m_rr + k) % NH]) own_n = (m_rr + k) % NH;
               end
            end
         end else begin
            if (!PROC_SYS_RESETN) begin
               own_n   = OWN_NONE;
               guard_n = G;
            end else if (!HOST_REQ[m_own] && HOST_SS[m_own]) begin
               own_n   = OWN_NONE;
               guard_n = G;
               rr_n    = (m_own + 1) % NH;
            end
         end
         m_own   <= own_n;
         m_guard <= guard_n;
         m_rr    <= rr_n;
         m_viol  <= v;
      end
   end

   function automatic logic [15:0] exp_bus();
      logic [NH-1:0] g;
      logic          ss, sck, sdo;
      g = '0;
      if (m_own == OWN_BOOT) begin
         ss = boot_ss; sck = boot_sck; sdo = boot_sdo;
      end else if (m_own >= 0) begin
         g[m_own] = 1'b1;
         ss = HOST_SS[m_own]; sck = HOST_SCK[m_own]; sdo = HOST_SDO[m_own];
      end else begin
         ss = 1'b1; sck = IDLE_SCK; sdo = 1'b0;
      end
      return {7'b0, g, ss, sck, sdo, m_viol, FLASH_SDI, {NH{FLASH_SDI}}};
   endfunction

   task automatic tick();
      @(posedge HCLK);
      @(negedge HCLK);
   endtask

   task automatic jitter();
      boot_sck  = 1'($urandom);
      boot_sdo  = 1'($urandom);
      HOST_SCK  = NH'($urandom);
      HOST_SDO  = NH'($urandom);
      FLASH_SDI = 1'($urandom);
   endtask

   task automatic go_idle();
      HOST_REQ        = '0;
      HOST_SS         = '1;
      boot_active     = 1'b0;
      boot_ss         = 1'b1;
      PROC_SYS_RESETN = 1'b1;
      repeat (G + 4) tick();
   endtask

   task automatic test_reset();
      int zeros;
      boot_active = 1'b1; boot_ss = 1'b0; PROC_SYS_RESETN = 1'b1;
      HOST_REQ = '0; HOST_SS = '1;
      jitter();
      #1 HRESETN = 1'b0;
      #2;
      n_checks++;
      if (HOST_GNT !== '0 || FLASH_SS !== 1'b0 || FLASH_SCK !== boot_sck || act_bus !== exp_bus()) begin
         n_fail++;
         $display("FAIL reset_state got=%h exp=%h", act_bus, exp_bus());
      end
      repeat (2) tick();
      HRESETN = 1'b1;
      for (int i = 0; i < 6; i++) begin
         boot_ss = 1'($urandom);
         jitter();
         tick();
         n_checks++;
         if (act_bus !== exp_bus() || FLASH_SS !== boot_ss || FLASH_SDO !== boot_sdo || HOST_GNT !== '0) begin
            n_fail++;
            $display("FAIL reset_boot_mirror got=%h exp=%h", act_bus, exp_bus());
         end
      end
      boot_active = 1'b0; boot_ss = 1'b1; HOST_REQ = 2'b01;
      tick();
      zeros = 0;
      for (int k = 0; k < 20 && HOST_GNT == '0; k++) begin
         n_checks++;
         if (act_bus !== exp_bus() || FLASH_SS !== 1'b1) begin
            n_fail++;
            $display("FAIL boot_guard got=%h exp=%h", act_bus, exp_bus());
         end
         zeros++;
         jitter();
         tick();
      end
      n_checks++;
      if (zeros != G + 1 || HOST_GNT !== 2'b01) begin
         n_fail++;
         $display("FAIL boot_handoff gap=%0d gnt=%b exp_gap=%0d exp_gnt=01", zeros, HOST_GNT, G + 1);
      end
   endtask

   task automatic test_round_robin();
      HOST_REQ = 2'b11;
      for (int r = 0; r < 3; r++) begin
         automatic int e     = r % 2;
         automatic int zeros = 0;
         n_checks++;
         if (HOST_GNT !== NH'(1 << e)) begin
            n_fail++;
            $display("FAIL rr_order round=%0d gnt=%b exp=%b", r, HOST_GNT, NH'(1 << e));
         end
         HOST_SS[e] = 1'b0;
         repeat (3) begin
            jitter();
            tick();
            n_checks++;
            if (act_bus !== exp_bus()) begin
               n_fail++;
               $display("FAIL rr_xfer got=%h exp=%h", act_bus, exp_bus());
            end
         end
         HOST_SS[e] = 1'b1; HOST_REQ[e] = 1'b0;
         tick();
         HOST_REQ[e] = 1'b1;
         for (int k = 0; k < 20 && HOST_GNT == '0; k++) begin
            n_checks++;
            if (act_bus !== exp_bus() || FLASH_SS !== 1'b1) begin
               n_fail++;
               $display("FAIL rr_guard got=%h exp=%h", act_bus, exp_bus());
            end
            zeros++;
            tick();
         end
         n_checks++;
         if (zeros != G + 1) begin
            n_fail++;
            $display("FAIL rr_gap got=%0d exp=%0d", zeros, G + 1);
         end
      end
      go_idle();
   endtask

   task automatic test_ss_hold();
      HOST_REQ = 2'b01;
      tick();
      n_checks++;
      if (HOST_GNT !== 2'b01 || act_bus !== exp_bus()) begin
         n_fail++;
         $display("FAIL hold_latency gnt=%b exp=01", HOST_GNT);
      end
      HOST_SS[0] = 1'b0;
      jitter();
      tick();
      HOST_REQ[0] = 1'b0;
      repeat (4) begin
         jitter();
         tick();
         n_checks++;
         if (HOST_GNT !== 2'b01 || FLASH_SS !== 1'b0 || act_bus !== exp_bus()) begin
            n_fail++;
            $display("FAIL hold_gnt gnt=%b ss=%b exp_gnt=01 exp_ss=0", HOST_GNT, FLASH_SS);
         end
      end
      HOST_SS[0] = 1'b1;
      tick();
      repeat (G) begin
         n_checks++;
         if (HOST_GNT !== '0 || FLASH_SS !== 1'b1 || act_bus !== exp_bus()) begin
            n_fail++;
            $display("FAIL hold_guard gnt=%b ss=%b exp_gnt=00 exp_ss=1", HOST_GNT, FLASH_SS);
         end
         tick();
      end
      n_checks++;
      if (FLASH_SS !== 1'b1 || act_bus !== exp_bus()) begin
         n_fail++;
         $display("FAIL hold_idle got=%h exp=%h", act_bus, exp_bus());
      end
      go_idle();
   endtask

   task automatic test_boot_priority();
      int hi;
      boot_active = 1'b1; boot_ss = 1'b0; HOST_REQ = 2'b10;
      tick();
      n_checks++;
      if (HOST_GNT !== '0 || FLASH_SS !== 1'b0 || act_bus !== exp_bus()) begin
         n_fail++;
         $display("FAIL prio_boot gnt=%b ss=%b exp_gnt=00 exp_ss=0", HOST_GNT, FLASH_SS);
      end
      boot_active = 1'b0; boot_ss = 1'b1;
      tick();
      for (int k = 0; k < 20 && HOST_GNT == '0; k++) tick();
      n_checks++;
      if (HOST_GNT !== 2'b10) begin
         n_fail++;
         $display("FAIL prio_host_gnt gnt=%b exp=10", HOST_GNT);
      end
      HOST_SS[1] = 1'b0; boot_active = 1'b1; boot_ss = 1'b0;
      repeat (3) begin
         jitter();
         tick();
         n_checks++;
         if (HOST_GNT !== 2'b10 || act_bus !== exp_bus()) begin
            n_fail++;
            $display("FAIL prio_no_preempt gnt=%b exp=10", HOST_GNT);
         end
      end
      HOST_REQ[1] = 1'b0; HOST_SS[1] = 1'b1;
      tick();
      hi = 0;
      for (int k = 0; k < 20 && FLASH_SS === 1'b1; k++) begin
         n_checks++;
         if (HOST_GNT !== '0 || act_bus !== exp_bus()) begin
            n_fail++;
            $display("FAIL prio_gap_bus got=%h exp=%h", act_bus, exp_bus());
         end
         hi++;
         tick();
      end
      n_checks++;
      if (hi != G + 1 || HOST_GNT !== '0 || FLASH_SCK !== boot_sck || act_bus !== exp_bus()) begin
         n_fail++;
         $display("FAIL prio_boot_return ss_high=%0d exp=%0d gnt=%b", hi, G + 1, HOST_GNT);
      end
      go_idle();
   endtask

   task automatic test_proc_reset();
      HOST_REQ = 2'b01;
      tick();
      HOST_SS[0] = 1'b0;
      jitter();
      tick();
      n_checks++;
      if (HOST_GNT !== 2'b01 || FLASH_SS !== 1'b0) begin
         n_fail++;
         $display("FAIL proc_gnt gnt=%b exp=01", HOST_GNT);
      end
      PROC_SYS_RESETN = 1'b0; HOST_REQ = 2'b11;
      tick();
      n_checks++;
      if (HOST_GNT !== '0 || FLASH_SS !== 1'b1 || ss_violation !== 1'b0 || act_bus !== exp_bus()) begin
         n_fail++;
         $display("FAIL proc_abort gnt=%b ss=%b viol=%b exp 00/1/0", HOST_GNT, FLASH_SS, ss_violation);
      end
      HOST_SS[0] = 1'b1;
      repeat (10) begin
         jitter();
         tick();
         n_checks++;
         if (HOST_GNT !== '0 || act_bus !== exp_bus()) begin
            n_fail++;
            $display("FAIL proc_ignored gnt=%b exp=00", HOST_GNT);
         end
      end
      PROC_SYS_RESETN = 1'b1;
      tick();
      n_checks++;
      if (HOST_GNT !== 2'b01 || act_bus !== exp_bus()) begin
         n_fail++;
         $display("FAIL proc_resume_rr gnt=%b exp=01", HOST_GNT);
      end
   endtask

   task automatic test_violation();
      HOST_SS[0] = 1'b1; HOST_SS[1] = 1'b0;
      tick();
      n_checks++;
      if (ss_violation !== 1'b1 || FLASH_SS !== 1'b1 || act_bus !== exp_bus()) begin
         n_fail++;
         $display("FAIL viol_pulse viol=%b ss=%b exp 1/1", ss_violation, FLASH_SS);
      end
      HOST_SS[1] = 1'b1;
      tick();
      n_checks++;
      if (ss_violation !== 1'b0 || act_bus !== exp_bus()) begin
         n_fail++;
         $display("FAIL viol_clear viol=%b exp=0", ss_violation);
      end
      HOST_SS[0] = 1'b0;
      jitter();
      tick();
      boot_active = 1'b1; boot_ss = 1'b0;
      #1 HRESETN = 1'b0;
      #1;
      n_checks++;
      if (HOST_GNT !== '0 || FLASH_SS !== 1'b0 || FLASH_SCK !== boot_sck || act_bus !== exp_bus()) begin
         n_fail++;
         $display("FAIL hreset_mid gnt=%b ss=%b exp 00/0", HOST_GNT, FLASH_SS);
      end
      tick();
      HRESETN = 1'b1;
      go_idle();
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         if (m_own == OWN_BOOT) boot_active = ($urandom_range(0, 7) != 0);
         else                   boot_active = ($urandom_range(0, 39) == 0);
         boot_ss         = 1'($urandom);
         PROC_SYS_RESETN = ($urandom_range(0, 49) != 0);
         for (int h = 0; h < NH; h++) begin
            if (h == m_own) begin
               HOST_REQ[h] = ($urandom_range(0, 5) != 0);
               HOST_SS[h]  = 1'($urandom);
            end else begin
               HOST_REQ[h] = 1'($urandom);
               HOST_SS[h]  = ($urandom_range(0, 29) != 0);
            end
         end
         jitter();
         tick();
         n_checks++;
         if (act_bus !== exp_bus()) begin
            n_fail++;
            $display("FAIL rand_bus cycle=%0d got=%h exp=%h", c, act_bus, exp_bus());
         end
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_ss_hold();
      test_boot_priority();
      test_proc_reset();
      test_violation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog t=%0t limit reached", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/corebootstrap_spi_arb.md
# corebootstrap_spi_arb

Parametrised SPI flash arbiter that succeeds the two-way boot/host select. It shares one SPI flash chip between the CoreBootStrap copy engine and 1–4 host SPI masters. Hosts use a per-host request/grant handshake with round-robin fairness, and the bootstrap engine has priority. A guard interval, with FLASH_SS forced high, separates every change of bus owner. It sits between the bootstrap engine, the host CPUs' SPI controllers and the flash pads.

## Interface
- NUM_HOSTS, 2: number of host SPI masters; legal range 1..4.
- GUARD_CYCLES, 4: HCLK cycles FLASH_SS is held high between owners; legal range 1..255.
- IDLE_SCK, 1'b0: level driven on FLASH_SCK when no owner is selected (SPI CPOL).
- HCLK  in  1  block clock; all inputs are synchronous to HCLK.
- HRESETN  in  1  reset, asynchronous, active-low.
- PROC_SYS_RESETN  in  1  host CPU reset, active-low; low forces all host requests ignored.
- boot_active  in  1  bootstrap engine wants the flash; high during copy.
- boot_sck, boot_sdo, boot_ss  in  1 each  bootstrap SPI signals.
- boot_sdi  out  1  equals FLASH_SDI.
- HOST_REQ  in  NUM_HOSTS  per-host bus request.
- HOST_GNT  out  NUM_HOSTS  per-host grant, registered, one-hot or zero.
- HOST_SCK, HOST_SDO, HOST_SS  in  NUM_HOSTS each  host SPI signals.
- HOST_SDI  out  NUM_HOSTS  every bit equals FLASH_SDI.
- FLASH_SCK, FLASH_SDO, FLASH_SS  out  1 each  to flash.
- FLASH_SDI  in  1  from flash.
- ss_violation  out  1  registered one-cycle pulse.

## Operation
- States: BOOT, GUARD, IDLE, HOST. The registered owner index `cur` is 0..NUM_HOSTS-1. The rr pointer `nxt` has the same range.
- Output mux:
  - BOOT: FLASH_* follow boot_*.
  - HOST: FLASH_* follow host[cur].
  - GUARD/IDLE: FLASH_SS=1, FLASH_SCK=IDLE_SCK, FLASH_SDO=0.
  - The mux is combinational from registered state only.
- BOOT:
  - Exit to GUARD when boot_active=0 and boot_ss=1 are sampled on the same edge.
  - HOST_GNT=0 throughout.
- GUARD:
  - The down-counter loads GUARD_CYCLES-1 on entry and decrements each cycle.
  - At 0, go to IDLE.
  - Requests are ignored while in GUARD.
- IDLE:
  - If boot_active=1, go to BOOT. Boot wins a simultaneous host request.
  - Else if PROC_SYS_RESETN=1 and any HOST_REQ bit is set, grant the first requester scanning from `nxt` upward with wrap-around, and go to HOST.
  - Else stay in IDLE.
- HOST:
  - Exit when HOST_REQ[cur]=0 and HOST_SS[cur]=1 are sampled on the same edge. Then go to GUARD and set nxt=(cur+1) mod NUM_HOSTS.
  - Dropping REQ while SS=0 does not release the bus; the grant holds until SS rises.
  - PROC_SYS_RESETN=0 aborts: go to GUARD immediately, ignoring SS, with nxt unchanged.
  - boot_active rising does not preempt the host. Boot is served at the next IDLE.
- ss_violation pulses for one cycle when any non-granted host has HOST_SS=0 while PROC_SYS_RESETN=1. That host's SS never reaches the flash.
- Reset values:
  - State BOOT, cur=0, nxt=0.
  - HOST_GNT=0, ss_violation=0.
  - FLASH_* follow boot_*.

## Timing
- Grant latency: a request sampled in IDLE at edge n gives HOST_GNT high and the FLASH mux switched after edge n. The host may assert SS from cycle n+1.
- Release: the release condition sampled at edge n drops GNT after edge n. FLASH_SS is then high for exactly GUARD_CYCLES cycles in GUARD, followed by at least 1 cycle in IDLE. The next grant therefore comes no earlier than GUARD_CYCLES+1 edges after release.
- Boot handoff takes the same path: boot release, then GUARD, then IDLE.
- HRESETN assertion mid-transfer immediately (asynchronously) returns the block to BOOT. Any host transfer is truncated.
- Counter width is 8 bits; GUARD_CYCLES=1 gives a single guard cycle.

## Test plan
- Reset release with boot_active=1 → FLASH_* mirror boot_*, HOST_GNT=0. Drop boot_active with boot_ss=1 → FLASH_SS=1 for 4 cycles, then IDLE.
- NUM_HOSTS=2, both REQ high continuously in IDLE → grants go host0, host1, host0, with 4 guard cycles plus 1 idle cycle between them. Each GNT rises 1 cycle after IDLE entry.
- Host0 drops REQ while HOST_SS[0]=0 → GNT[0] stays high. SS rises at edge n → GNT[0]=0 after edge n, and FLASH_SS=1 for 4 cycles.
- boot_active and HOST_REQ[1] both high in IDLE → BOOT is entered and GNT stays 0. boot_active rising during a HOST transfer → the host finishes, then GUARD, then IDLE, then BOOT.
- PROC_SYS_RESETN pulled low during a host transfer with SS=0 → GUARD on the next edge, GNT=0, FLASH_SS=1. Requests stay ignored while PROC_SYS_RESETN=0.
- HOST_SS[1]=0 while host0 holds the grant → ss_violation=1 for 1 cycle and FLASH_SS follows host0. HRESETN pulsed mid-transfer → BOOT with all GNT=0.
